// File: rtl/dec_sub_decode_pkg.sv
// rtl/dec_sub_decode_pkg.sv - ring constants and coefficient helpers for the decode stage
// Purpose: Kyber ring parameters, the message-decode thresholds and the
//          coefficient canonicalize helper shared by the decode datapath.
// Ports:   none (package).
package dec_sub_decode_pkg;

  localparam int KYBER_N       = 256;
  localparam int KYBER_R_WIDTH = 12;

  localparam logic [KYBER_R_WIDTH-1:0] KYBER_Q          = KYBER_R_WIDTH'(3329);
  // d in [Q_QUART_LO, Q_QUART_HI] rounds to q/2, i.e. decodes to a 1.
  localparam logic [KYBER_R_WIDTH-1:0] KYBER_Q_QUART_LO = KYBER_R_WIDTH'(833);
  localparam logic [KYBER_R_WIDTH-1:0] KYBER_Q_QUART_HI = KYBER_R_WIDTH'(2496);

  // A 12-bit value is below 2q, so a single conditional subtract canonicalizes it.
  function automatic logic [KYBER_R_WIDTH-1:0] canon(input logic [KYBER_R_WIDTH-1:0] x);
    return (x >= KYBER_Q) ? (x - KYBER_Q) : x;
  endfunction

endpackage

// File: rtl/dec_sub_decode_lane.sv
// rtl/dec_sub_decode_lane.sv - one-coefficient (v - w) mod q followed by 1-bit compress
// Purpose: combinational decode of one coefficient pair to one message bit.
// Ports:   v_coeff - 12-bit ciphertext coefficient (any 12-bit value)
//          w_coeff - 12-bit s^T*u coefficient (any 12-bit value)
//          bit_out - decoded message bit
module decode_lane
  import dec_sub_decode_pkg::*;
(
  input  logic [KYBER_R_WIDTH-1:0] v_coeff,
  input  logic [KYBER_R_WIDTH-1:0] w_coeff,
  output logic                     bit_out
);

  logic [KYBER_R_WIDTH-1:0] a_v;
  logic [KYBER_R_WIDTH-1:0] a_w;
  logic [KYBER_R_WIDTH:0]   diff;
  logic [KYBER_R_WIDTH-1:0] d;

  assign a_v  = canon(v_coeff);
  assign a_w  = canon(w_coeff);
  // Extra MSB acts as the borrow: set when a_v < a_w.
  assign diff = {1'b0, a_v} - {1'b0, a_w};
  // Adding q modulo 2^12 to the wrapped difference lands exactly in [0, q-1].
  assign d    = diff[KYBER_R_WIDTH] ? (diff[KYBER_R_WIDTH-1:0] + KYBER_Q)
                                    : diff[KYBER_R_WIDTH-1:0];

  assign bit_out = (d >= KYBER_Q_QUART_LO) && (d <= KYBER_Q_QUART_HI);

endmodule

// File: rtl/dec_sub_decode.sv
// rtl/dec_sub_decode.sv - serialized (v - w) decode of a polynomial into the 256-bit message
// Purpose: decodes LANES coefficients per cycle into msg; IDLE -> RUN -> DONE.
// Ports:   clk, rst     - clock; asynchronous active-high reset
//          enable       - start request, honoured in IDLE or DONE
//          v, w         - packed polynomials, coeff i at [12i+11:12i], held stable until valid
//          msg          - decoded message, bit i from coeff i
//          busy         - high while decoding
//          valid        - high when msg is complete
module dec_sub_decode
  import dec_sub_decode_pkg::*;
#(
  parameter int LANES = 16
)
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [KYBER_N*KYBER_R_WIDTH-1:0]   v,
  input  logic [KYBER_N*KYBER_R_WIDTH-1:0]   w,
  output logic [KYBER_N-1:0]                 msg,
  output logic                               busy,
  output logic                               valid
);

  localparam int CHUNKS = KYBER_N / LANES;
  localparam int IDX_W  = $clog2(CHUNKS);
  localparam int LANE_W = $clog2(LANES);
  localparam int CIDX_W = $clog2(KYBER_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LANES-1:0] lane_bits;

  // LANES is a power of two, so coefficient index = {idx, lane}.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [LANE_W-1:0] LID = LANE_W'(l);
    logic [CIDX_W-1:0] cidx;
    assign cidx = {idx_q, LID};

    decode_lane u_lane (
      .v_coeff (v[cidx*KYBER_R_WIDTH +: KYBER_R_WIDTH]),
      .w_coeff (w[cidx*KYBER_R_WIDTH +: KYBER_R_WIDTH]),
      .bit_out (lane_bits[l])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (enable) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      msg     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == ST_RUN) begin
        msg[{idx_q, {LANE_W{1'b0}}} +: LANES] <= lane_bits;
      end
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_dec_sub_decode.sv
// tb/tb_dec_sub_decode.sv - randomized self-checking bench for dec_sub_decode at LANES 16/8/32
module tb_dec_sub_decode;

  localparam int N  = 256;
  localparam int Q  = 3329;
  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic [N*12-1:0] v = '0;
  logic [N*12-1:0] w = '0;
  logic [N-1:0]    msg_a   [ND];
  logic            busy_a  [ND];
  logic            valid_a [ND];

  int chunks [ND] = '{16, 32, 8};
  int vc [N];
  int wc [N];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_sub_decode #(.LANES(16)) dut0 (.clk(clk), .rst(rst), .enable(enable), .v(v), .w(w),
                                     .msg(msg_a[0]), .busy(busy_a[0]), .valid(valid_a[0]));
  dec_sub_decode #(.LANES(8))  dut1 (.clk(clk), .rst(rst), .enable(enable), .v(v), .w(w),
                                     .msg(msg_a[1]), .busy(busy_a[1]), .valid(valid_a[1]));
  dec_sub_decode #(.LANES(32)) dut2 (.clk(clk), .rst(rst), .enable(enable), .v(v), .w(w),
                                     .msg(msg_a[2]), .busy(busy_a[2]), .valid(valid_a[2]));

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: reduce mod q, subtract mod q, then round(2d/q) mod 2 in integer form.
  function automatic logic [N-1:0] ref_msg();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin
      int av, aw, d;
      av = vc[i] % Q;
      aw = wc[i] % Q;
      d  = ((av - aw) % Q + Q) % Q;
      m[i] = (((4 * d + Q) / (2 * Q)) % 2) == 1;
    end
    return m;
  endfunction

  task automatic load();
    for (int i = 0; i < N; i++) begin
      v[i*12 +: 12] = 12'(vc[i]);
      w[i*12 +: 12] = 12'(wc[i]);
    end
  endtask

  task automatic fill(input int vv, input int ww);
    for (int i = 0; i < N; i++) begin
      vc[i] = vv;
      wc[i] = ww;
    end
    load();
  endtask

  // One enable pulse, then watch every DUT for 40 cycles; pulse_at > 0 re-pulses
  // enable at that cycle of RUN, which must not disturb anything.
  task automatic run(input string tag, input logic [N-1:0] exp, input int pulse_at);
    int lat [ND];
    int bcnt [ND];
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    for (int d = 0; d < ND; d++) begin
      lat[d]  = 0;
      bcnt[d] = busy_a[d] ? 1 : 0;
      if (valid_a[d]) check({tag, "_valid_early"}, 1, 0);
    end
    for (int c = 1; c <= 40; c++) begin
      enable = (c == pulse_at);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (busy_a[d]) bcnt[d]++;
        if (valid_a[d] && lat[d] == 0) lat[d] = c;
      end
    end
    enable = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_msg%0d", tag, d), msg_a[d], exp);
      check($sformatf("%s_lat%0d", tag, d), N'(lat[d]), N'(chunks[d]));
      check($sformatf("%s_busy%0d", tag, d), N'(bcnt[d]), N'(chunks[d]));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_msg%0d", tag, d), msg_a[d], '0);
      check($sformatf("%s_bv%0d", tag, d), {busy_a[d], valid_a[d]}, '0);
    end
  endtask

  initial begin
    logic [N-1:0] m;
    logic [N-1:0] pat;
    int gap_last [ND];

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    fill(1234, 1234);
    run("equal", '0, 0);

    fill(1665, 0);
    run("half", '1, 0);

    fill(0, 1664);
    run("negwrap", '1, 0);

    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: vc[i] = 832;
        1: vc[i] = 833;
        2: vc[i] = 2496;
        default: vc[i] = 2497;
      endcase
      wc[i] = 0;
    end
    load();
    pat = {64{4'h6}};
    check("thr_model", ref_msg(), pat);
    run("thresh", pat, 0);

    fill(4095, 0);
    run("nc_4095_0", '0, 0);
    fill(4095, 4095);
    run("nc_4095_4095", '0, 0);
    fill(3329, 2496);
    run("nc_3329_2496", '1, 0);

    // Enable re-pulsed mid-RUN must not restart or stretch the run.
    for (int i = 0; i < N; i++) begin
      vc[i] = $urandom_range(0, 4095);
      wc[i] = $urandom_range(0, 4095);
    end
    load();
    run("midpulse", ref_msg(), 4);

    // Reset at cycle 8 of RUN aborts everything; rst+enable together stays idle.
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", N'(busy_a[0]), N'(1));
    rst = 1'b1;
    enable = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    check_reset_state("rst_en");
    rst = 1'b0;
    enable = 1'b0;
    run("after_rst", ref_msg(), 0);

    // Round-trip: encoded message plus bounded noise decodes back to m.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        int noise;
        m[i]  = $urandom_range(0, 1) == 1;
        noise = $urandom_range(0, 800) - 400;
        vc[i] = ((m[i] ? 1665 : 0) + noise + Q) % Q;
        wc[i] = 0;
      end
      load();
      run($sformatf("rt%0d", t), m, 0);
    end

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        vc[i] = $urandom_range(0, 4095);
        wc[i] = $urandom_range(0, 4095);
      end
      load();
      run($sformatf("rand%0d", t), ref_msg(), 0);
    end

    // Enable held high: each DUT restarts from DONE at once, so valid is high
    // for one cycle every chunks+1 cycles.
    for (int d = 0; d < ND; d++) gap_last[d] = -1;
    @(negedge clk) enable = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (valid_a[d]) begin
          if (gap_last[d] >= 0)
            check($sformatf("b2b_gap%0d", d), N'(c - gap_last[d]), N'(chunks[d] + 1));
          gap_last[d] = c;
        end
      end
    end
    enable = 1'b0;
    for (int d = 0; d < ND; d++) begin
      if (gap_last[d] < 0) check($sformatf("b2b_seen%0d", d), 0, 1);
    end
    repeat (40) @(negedge clk);
    for (int d = 0; d < ND; d++)
      check($sformatf("b2b_msg%0d", d), msg_a[d], ref_msg());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_sub_decode.md
# dec_sub_decode

Decryption-side counterpart of the encryption add stage: takes the ciphertext polynomial `v` and the product `w = NTT^-1(s^T · u)`, forms `(v - w) mod q` per coefficient, and decodes each coefficient to one message bit (Compress_q(·,1)). It sits after the inverse-NTT/accumulate path of the decryption datapath and produces the 256-bit message `m'` consumed by the re-encryption/hash stage. Processing is serialized over `LANES` coefficients per cycle.

## Interface
- `LANES`, 16, coefficients processed per cycle; must divide `KYBER_N` (legal: 8, 16, 32, 64).
- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high.
- `enable`  input  1  start request, sampled in IDLE or DONE.
- `v`  input  `KYBER_N*KYBER_R_WIDTH`  ciphertext poly; coeff i at bits [12i+11:12i].
- `w`  input  `KYBER_N*KYBER_R_WIDTH`  s^T·u poly, same packing.
- `msg`  output  `KYBER_N`  decoded message; bit i from coeff i.
- `busy`  output  1  high while in RUN.
- `valid`  output  1  high in DONE; `msg` complete and stable.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `enable`=1 → RUN, chunk counter `idx`←0, `valid`←0.
  - RUN: each cycle process coeffs `idx*LANES` … `idx*LANES+LANES-1`, write their bits into `msg`; `idx`++. On last chunk (`idx = KYBER_N/LANES-1`) → DONE, `valid`←1.
  - DONE: hold `msg`, `valid`=1. `enable`=1 → RUN as from IDLE (`valid`←0 same edge, `msg` overwritten chunk by chunk).
- `enable` during RUN ignored; no queuing.
- `v`, `w` must be held stable from the accepting edge until `valid`; not latched internally.
- Per-lane arithmetic (12-bit in, 1-bit out):
  - Canonicalize: a = x ≥ 3329 ? x − 3329 : x, for both v and w coeff (covers full 12-bit range; 4095→766).
  - d = a_v − a_w; if negative, d += 3329. Result in [0, 3328], 12 bits.
  - bit = 1 iff 833 ≤ d ≤ 2496, else 0 (equals round(2d/q) mod 2).
- `msg` bits not yet written in a run keep their previous value.

## Timing
- Reset values: state IDLE, `idx`=0, `msg`=0, `busy`=0, `valid`=0.
- `enable` high at edge k (IDLE/DONE) → `busy`=1 after edge k; chunks 0…N/LANES−1 written at edges k+1…k+N/LANES; `valid`=1, `busy`=0 after edge k+N/LANES (16 cycles at LANES=16).
- Back-to-back: `enable` held high in DONE restarts immediately; `valid` low for exactly N/LANES cycles.
- `rst` mid-RUN: immediate abort to reset values; no partial `valid`.
- `rst` and `enable` together: reset wins.
- Datapath combinational within one cycle from `v`/`w` slice to `msg` register; no pipeline stage.

## Structure
- `params.vh` supplies `KYBER_N`, `KYBER_Q` (3329), `KYBER_R_WIDTH` (12); add `KYBER_Q_QUART_LO` (833) and `KYBER_Q_QUART_HI` (2496) there; no literals of q in RTL.
- State encoding localparam in this module.
- Sub-module `decode_lane`: combinational, one 12-bit v coeff + one w coeff → 1 bit (canonicalize, modular subtract, threshold); instantiated `LANES` times via generate; slice selected by `idx`.

## Test plan
- v = w = all 1234 → `msg` = 0 all bits; `valid` after exactly 16 cycles, `busy` 16 cycles.
- v = all 1665, w = 0 → `msg` all 1s; then v = 0, w = all 1664 (negative wrap, d = 1665) → all 1s.
- Thresholds: w = 0, coeffs of v cycling 832, 833, 2496, 2497 → bits 0,1,1,0 repeating (msg = 0x6666…6 pattern per nibble LSB-first).
- Non-canonical: v = 4095, w = 0 → d = 766 → 0; v = 4095, w = 4095 → 0; v = 3329, w = 2496 → d = 833 → 1.
- Control: `enable` pulsed mid-RUN → no effect on latency; `rst` at cycle 8 of RUN → all outputs 0, next `enable` gives correct full result.
- Round-trip: random 256-bit m, v = 1665·m_i + random noise in [−400, 400] mod q, w = 0 → `msg` = m; sweep LANES = 8, 32.
